// File: rtl/dmem_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: access sizes, FSM states and owner tags.
package mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'b00,
    OWNER_I    = 2'b01,
    OWNER_D    = 2'b10
  } owner_e;

endpackage

// File: rtl/dmem_port_arbiter_starve.sv
// Winner select for the shared memory port: data side has priority unless fetch has lost
// STARVE conflicts in a row, in which case fetch wins the next conflict.
module arb_starve_ctr
  import mem_pkg::*;
#(
  parameter int STARVE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_fetch_req,
  input  logic i_data_req,
  input  logic i_grant_en,
  output logic o_grant_fetch
);

  localparam int SW = (STARVE > 0) ? $clog2(STARVE + 1) : 1;
  localparam logic [SW-1:0] SAT = SW'(STARVE);

  logic [SW-1:0] r_cnt;
  logic          w_sat;

  assign w_sat         = (r_cnt == SAT);
  assign o_grant_fetch = i_fetch_req & (~i_data_req | w_sat);

  // Counter only moves on an actual grant; a lost conflict is a grant to D while I was asking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_grant_en) begin
      if (o_grant_fetch) begin
        r_cnt <= '0;
      end else if (i_fetch_req && !w_sat) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter in front of a single-ported, variable-latency data memory with
// one access in flight, registered done pulses and a watchdog that aborts hung accesses.
module dmem_port_arbiter
  import mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int STARVE  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

  state_e        r_state, w_state_next;
  owner_e        r_owner;
  logic [WW-1:0] r_wait;
  logic [DW-1:0] r_data;
  logic          r_abort;
  logic          r_i_done, r_d_done, r_err;
  logic [DW-1:0] r_i_rdata, r_d_rdata;
  logic          r_mem_req, r_mem_we;
  logic [1:0]    r_mem_size;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  logic w_grant_en, w_grant_i, w_capture, w_abort, w_timeout_hit;

  arb_starve_ctr #(
    .STARVE(STARVE)
  ) u_starve (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_fetch_req  (i_req),
    .i_data_req   (d_req),
    .i_grant_en   (w_grant_en),
    .o_grant_fetch(w_grant_i)
  );

  assign w_timeout_hit = (TIMEOUT != 0) && (r_wait == WAIT_LAST);

  always_comb begin
    w_state_next = r_state;
    w_grant_en   = 1'b0;
    w_capture    = 1'b0;
    w_abort      = 1'b0;
    unique case (r_state)
      // The done-pulse cycle still sees the finished requester's req, so no grant then.
      ST_IDLE: begin
        if ((i_req || d_req) && !r_i_done && !r_d_done) begin
          w_grant_en   = 1'b1;
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          w_capture    = 1'b1;
          w_state_next = ST_DONE;
        end else if (w_timeout_hit) begin
          w_abort      = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner     <= OWNER_NONE;
      r_wait      <= '0;
      r_data      <= '0;
      r_abort     <= 1'b0;
      r_i_done    <= 1'b0;
      r_d_done    <= 1'b0;
      r_err       <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_size  <= SZ_WORD;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      r_err    <= 1'b0;
      if (w_grant_en) begin
        r_owner     <= w_grant_i ? OWNER_I : OWNER_D;
        r_wait      <= '0;
        r_mem_req   <= 1'b1;
        r_mem_we    <= w_grant_i ? 1'b0 : d_we;
        r_mem_size  <= w_grant_i ? SZ_WORD : d_size;
        r_mem_addr  <= w_grant_i ? i_addr : d_addr;
        r_mem_wdata <= w_grant_i ? '0 : d_wdata;
      end
      if (w_capture) begin
        r_mem_req <= 1'b0;
        r_data    <= mem_rdata;
        r_abort   <= 1'b0;
      end else if (w_abort) begin
        r_mem_req <= 1'b0;
        r_data    <= '0;
        r_abort   <= 1'b1;
      end else if (r_state == ST_BUSY) begin
        r_wait <= r_wait + 1'b1;
      end
      // Read data is published together with the done pulse so it holds between dones.
      if (r_state == ST_DONE) begin
        if (r_owner == OWNER_I) begin
          r_i_done  <= 1'b1;
          r_i_rdata <= r_data;
        end else begin
          r_d_done  <= 1'b1;
          r_d_rdata <= r_data;
        end
        r_err   <= r_abort;
        r_owner <= OWNER_NONE;
      end
    end
  end

  assign i_done    = r_i_done;
  assign d_done    = r_d_done;
  assign err       = r_err;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_size  = r_mem_size;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign stall     = (i_req & ~r_i_done) | (d_req & ~r_d_done);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: reset, single load, starvation order, slow store,
// watchdog abort and reset during an access.
module tb_dmem_port_arbiter;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [1:0]  d_size;
  logic        i_done, d_done, err, stall;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  // Memory model: ready arrives in the mem_lat-th cycle of mem_req (0 = never).
  int mem_lat = 1;
  int busy_cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req && !mem_ready) busy_cyc <= busy_cyc + 1;
    else busy_cyc <= 0;
  end

  assign mem_ready = mem_req && (mem_lat > 0) && (busy_cyc == mem_lat - 1);
  assign mem_rdata = {mem_addr[15:0], 16'hC0DE};

  dmem_port_arbiter #(
    .AW(32), .DW(32), .STARVE(4), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .err(err), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_done(input int max, output bit got);
    got = 1'b0;
    for (int n = 0; n < max && !got; n++) begin
      tick();
      if (i_done || d_done) got = 1'b1;
    end
  endtask

  initial begin
    int exp_i [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit got;

    rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_size = SZ_WORD;
    i_addr = 32'h0000_0200; d_addr = 32'h0000_0300; d_wdata = '0;

    // 1: reset with both requesters active
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_ctrl", {mem_req, mem_we, i_done, d_done, err}, 5'b0);
      check("rst_data", {mem_addr, d_rdata}, 64'h0);
    end
    i_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;
    tick();
    check("rst_release", {mem_req, i_rdata}, 33'h0);
    $display("txn reset done");

    // 2: single D load, ready in the first memory cycle
    d_req = 1'b1; d_addr = 32'h0000_0100; d_size = SZ_WORD; d_we = 1'b0;
    tick();
    check("ld_issue", {mem_req, mem_we, mem_size, stall, d_done}, {1'b1, 1'b0, SZ_WORD, 1'b1, 1'b0});
    check("ld_addr", {32'h0, mem_addr}, 64'h100);
    tick();
    check("ld_wait", {mem_req, d_done}, 2'b00);
    tick();
    check("ld_done", {d_done, err, stall, i_done}, 4'b1000);
    check("ld_rdata", {32'h0, d_rdata}, 64'h0100_C0DE);
    $display("txn D load addr=%h rdata=%h", 32'h100, d_rdata);
    d_req = 1'b0;
    tick();
    check("ld_pulse", {d_done, mem_req}, 2'b00);

    // 3: both requesting continuously
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h0000_0200; d_addr = 32'h0000_0300;
    for (int t = 0; t < 10; t++) begin
      wait_done(8, got);
      check("starve_got", {63'h0, got}, 64'h1);
      check("starve_who", {i_done, d_done}, (exp_i[t] != 0) ? 2'b10 : 2'b01);
      if (exp_i[t] != 0) check("starve_ird", {32'h0, i_rdata}, 64'h0200_C0DE);
      else check("starve_drd", {32'h0, d_rdata}, 64'h0300_C0DE);
      $display("txn %0d winner=%s", t, i_done ? "I" : "D");
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();

    // 4: slow byte store, request inputs change after grant
    mem_lat = 11;
    d_req = 1'b1; d_we = 1'b1; d_size = SZ_BYTE; d_addr = 32'h0000_0044; d_wdata = 32'h0000_00AB;
    tick();
    for (int j = 0; j < 10; j++) begin
      if (j == 0) begin
        d_addr = 32'h0000_0999; d_wdata = 32'h0; d_size = SZ_WORD; d_we = 1'b0;
      end
      check("st_ctrl", {mem_req, mem_we, mem_size, stall, d_done}, {1'b1, 1'b1, SZ_BYTE, 1'b1, 1'b0});
      check("st_data", {mem_addr, mem_wdata}, {32'h44, 32'hAB});
      tick();
    end
    tick();
    check("st_pre", {d_done, stall}, 2'b01);
    tick();
    check("st_done", {d_done, err, stall}, 3'b100);
    $display("txn D store byte addr=44 wdata=ab");
    d_req = 1'b0;
    tick();
    check("st_single", {63'h0, d_done}, 64'h0);

    // 5: watchdog abort
    mem_lat = 0;
    d_req = 1'b1; d_we = 1'b0; d_size = SZ_WORD; d_addr = 32'h0000_0500;
    tick();
    for (int j = 0; j < 63; j++) tick();
    check("to_last", {mem_req, d_done}, 2'b10);
    tick();
    check("to_drop", {mem_req, d_done}, 2'b00);
    tick();
    check("to_done", {d_done, err}, 2'b11);
    check("to_rdata", {32'h0, d_rdata}, 64'h0);
    $display("txn D load addr=500 aborted err=%0d", err);
    d_req = 1'b0;
    tick();
    check("to_clear", {d_done, err}, 2'b00);

    // 6: reset while busy, then the held request is served normally
    mem_lat = 5;
    d_req = 1'b1; d_addr = 32'h0000_0600;
    tick();
    tick();
    check("rb_busy", {63'h0, mem_req}, 64'h1);
    rst_n = 1'b0;
    tick();
    check("rb_idle", {mem_req, d_done, err}, 3'b000);
    rst_n = 1'b1;
    wait_done(20, got);
    check("rb_got", {63'h0, got}, 64'h1);
    check("rb_done", {d_done, err, i_done}, 3'b100);
    check("rb_rdata", {32'h0, d_rdata}, 64'h0600_C0DE);
    $display("txn D load after reset rdata=%h", d_rdata);
    d_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
